stopwatch_timer: RTL and testbench
==================================

Name: stopwatch_timer

Overview:
Parametrised second-generation stopwatch/timer for the LD time-management datapath. It adds a tick prescaler, configurable minute range, count-down mode with preset load, lap capture, and expiry/overflow flags. It is driven by the command decoder and feeds the 7-segment display formatter. It replaces the fixed 6-bit, count-every-clock, up-only manager.

Parameters:
CLK_DIV, 1, clock cycles per one-second tick (>=1); 1 = advance every enabled cycle
MIN_W, 6, width of minute counter and minute ports
MAX_MIN, 59, largest minute value (< 2**MIN_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cmd  in  3  0 NOP, 1 START, 2 STOP, 3 RESET, 4 LAP, 5 LOAD; others = NOP
dir  in  1  0 count up, 1 count down; sampled only on START from IDLE
preset_min  in  MIN_W  countdown preset minutes
preset_sec  in  6  countdown preset seconds
state  out  3  IDLE=0, RUN=1, PAUSE=2, CLEAR=3, DONE=4
min  out  MIN_W  current minutes
sec  out  6  current seconds
lap_min  out  MIN_W  captured minutes
lap_sec  out  6  captured seconds
lap_valid  out  1  one-cycle pulse after a capture
expired  out  1  countdown reached 00:00, held until CLEAR
ovf  out  1  up-count wrapped past MAX_MIN:59, sticky until CLEAR
tick  out  1  prescaler pulse, debug

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, min=sec=0, lap_*=0, lap_valid=0, expired=0, ovf=0, prescaler=0, latched dir=0.
- Prescaler: runs only in RUN and pulses tick when the count equals CLK_DIV-1, then wraps to 0. It freezes in PAUSE and clears on START from IDLE and on CLEAR. With CLK_DIV=1, tick=1 on every RUN cycle.
- IDLE:
  - START -> RUN; latch dir.
  - If dir=1 and the counters read 00:00, the transition is START -> DONE instead, with expired=1 next cycle.
  - LOAD copies preset_min/preset_sec into min/sec. preset_sec>59 clamps to 59; preset_min>MAX_MIN clamps to MAX_MIN.
  - All other cmds are ignored.
  - Counters hold in IDLE and are not zeroed (LOAD values must survive).
- RUN, on tick, up mode:
  - sec+1.
  - At sec=59: sec=0, min+1.
  - At MAX_MIN:59: wrap to 0:00 and set ovf=1; the block keeps running.
- RUN, on tick, down mode:
  - sec-1.
  - At sec=0: sec=59, min-1.
  - The tick that produces 00:00 moves the state to DONE and sets expired=1 in the same cycle as the count update.
- RUN commands:
  - STOP -> PAUSE.
  - RESET -> CLEAR.
  - LAP captures.
  - START and LOAD are ignored.
- PAUSE:
  - START -> RUN (dir not resampled).
  - RESET -> CLEAR.
  - LAP captures.
  - Others are ignored.
- DONE: counters hold at 00:00, RESET -> CLEAR, others are ignored.
- CLEAR (one cycle): min=sec=0, expired=0, ovf=0, prescaler=0, then -> IDLE unconditionally. cmd is ignored. lap_* registers are retained.
- LAP capture: lap_min/lap_sec take the current registered min/sec (the pre-tick value if a tick coincides). lap_valid=1 for exactly the next cycle.
- Simultaneous events:
  - tick + STOP: the count advances and the state becomes PAUSE.
  - tick + RESET: CLEAR wins the next cycle; the tick's count update is discarded.
  - Down-count reaching 00:00 + STOP: DONE wins.
- All outputs are registered; state and counter changes are visible the cycle after the cmd or tick.
- Arithmetic is modulo within the fields; no out-of-range min/sec is ever visible.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encodings (IDLE, RUN, PAUSE, CLEAR, DONE);
  - cmd codes (NOP, START, STOP, RESET, LAP, LOAD);
  - SEC_MAX=59.
- Sub-module tick_gen(CLK_DIV) contains:
  - the prescaler counter (width $clog2(CLK_DIV)+1);
  - en and clr inputs;
  - the tick output.

Test Plan:
- CLK_DIV=4, dir=0, START, run 61*4 cycles -> min=1, sec=1; tick period is 4 cycles; STOP then 20 idle cycles -> values frozen; START resumes with prescaler phase preserved.
- MAX_MIN=2, CLK_DIV=1, up from 0:00 for 180 ticks -> 0:00, ovf=1, state stays RUN; RESET -> one CLEAR cycle then IDLE, ovf=0.
- LOAD preset 1:05, dir=1, START, CLK_DIV=1 -> after 65 ticks min=0, sec=0, state=DONE, expired=1; START/STOP ignored in DONE; RESET clears expired.
- LAP in RUN at 0:07, on the same cycle as a tick -> lap_sec=7 (pre-tick), lap_valid high for exactly one cycle, sec=8; LAP in PAUSE also captures.
- LOAD preset_sec=63, preset_min=MAX_MIN+3 in IDLE -> sec=59, min=MAX_MIN; LOAD in RUN is ignored.
- Assert rst low mid-RUN between clock edges -> all outputs are 0 and state=IDLE immediately, without waiting for a clock edge; dir=1 START at 00:00 from IDLE -> DONE next cycle, expired=1.

Source files
------------

// File: rtl/stopwatch_timer_pkg.sv
// Shared encodings and helpers for the stopwatch/timer datapath.
// Imported by the top level and by the bench-facing encodings.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_RESET = 3'd3;
    localparam logic [2:0] CMD_LAP   = 3'd4;
    localparam logic [2:0] CMD_LOAD  = 3'd5;

    localparam logic [5:0] SEC_MAX = 6'd59;

    function automatic logic [5:0] clamp_sec(input logic [5:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/stopwatch_timer_tick_gen.sv
// One-second tick prescaler: counts enabled cycles and pulses tick on the
// last count of each CLK_DIV period; freezes when disabled.
module tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_s;

    assign tick_s = en && (cnt_r == CNT_LAST);
    assign tick   = tick_s;

    // Prescaler counter: clear has priority, wraps after the tick cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch/timer with prescaled ticks, up/down counting, preset load,
// lap capture and expiry/overflow flags. All outputs come from registers.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 1,
    parameter int MIN_W   = 6,
    parameter int MAX_MIN = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cmd,
    input  logic             dir,
    input  logic [MIN_W-1:0] preset_min,
    input  logic [5:0]       preset_sec,
    output logic [2:0]       state,
    output logic [MIN_W-1:0] min,
    output logic [5:0]       sec,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic             lap_valid,
    output logic             expired,
    output logic             ovf,
    output logic             tick
);

    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);
    localparam logic [MIN_W-1:0] MIN_ZERO = {MIN_W{1'b0}};
    localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);

    state_e           state_r, state_n;
    logic [MIN_W-1:0] min_r, min_n;
    logic [5:0]       sec_r, sec_n;
    logic [MIN_W-1:0] lap_min_r, lap_min_n;
    logic [5:0]       lap_sec_r, lap_sec_n;
    logic             lap_valid_r, lap_valid_n;
    logic             expired_r, expired_n;
    logic             ovf_r, ovf_n;
    logic             dir_r, dir_n;
    logic             pre_en_s, pre_clr_s, tick_s;

    assign pre_en_s  = (state_r == ST_RUN);
    assign pre_clr_s = ((state_r == ST_IDLE) && (cmd == CMD_START)) || (state_r == ST_CLEAR);

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en_s),
        .clr  (pre_clr_s),
        .tick (tick_s)
    );

    // Next-state, counter, lap and flag computation
    always_comb begin
        state_n     = state_r;
        min_n       = min_r;
        sec_n       = sec_r;
        lap_min_n   = lap_min_r;
        lap_sec_n   = lap_sec_r;
        lap_valid_n = 1'b0;
        expired_n   = expired_r;
        ovf_n       = ovf_r;
        dir_n       = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd == CMD_START) begin
                    dir_n = dir;
                    if (dir && (min_r == MIN_ZERO) && (sec_r == 6'd0)) begin
                        state_n   = ST_DONE;
                        expired_n = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                    end
                end else if (cmd == CMD_LOAD) begin
                    min_n = (preset_min > MIN_LAST) ? MIN_LAST : preset_min;
                    sec_n = clamp_sec(preset_sec);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd == CMD_RESET) begin
                    // Pending tick update is dropped; CLEAR zeroes everything next
                    state_n = ST_CLEAR;
                end else begin
                    if (tick_s && dir_r) begin
                        sec_n = (sec_r == 6'd0) ? SEC_MAX : sec_r - 6'd1;
                        min_n = (sec_r == 6'd0) ? min_r - MIN_ONE : min_r;
                    end else if (tick_s) begin
                        sec_n = (sec_r == SEC_MAX) ? 6'd0 : sec_r + 6'd1;
                        min_n = (sec_r != SEC_MAX) ? min_r :
                                (min_r == MIN_LAST) ? MIN_ZERO : min_r + MIN_ONE;
                        ovf_n = ovf_r | ((sec_r == SEC_MAX) && (min_r == MIN_LAST));
                    end else begin
                        sec_n = sec_r;
                    end
                    if (tick_s && dir_r && (min_r == MIN_ZERO) && (sec_r == 6'd1)) begin
                        state_n   = ST_DONE;
                        expired_n = 1'b1;
                    end else if (cmd == CMD_STOP) begin
                        state_n = ST_PAUSE;
                    end else begin
                        state_n = ST_RUN;
                    end
                    if (cmd == CMD_LAP) begin
                        lap_min_n   = min_r;
                        lap_sec_n   = sec_r;
                        lap_valid_n = 1'b1;
                    end else begin
                        lap_valid_n = 1'b0;
                    end
                end
            end
            ST_PAUSE: begin
                if (cmd == CMD_START) begin
                    state_n = ST_RUN;
                end else if (cmd == CMD_RESET) begin
                    state_n = ST_CLEAR;
                end else if (cmd == CMD_LAP) begin
                    lap_min_n   = min_r;
                    lap_sec_n   = sec_r;
                    lap_valid_n = 1'b1;
                end else begin
                    state_n = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (cmd == CMD_RESET) begin
                    state_n = ST_CLEAR;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_CLEAR: begin
                min_n     = MIN_ZERO;
                sec_n     = 6'd0;
                expired_n = 1'b0;
                ovf_n     = 1'b0;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            min_r       <= MIN_ZERO;
            sec_r       <= 6'd0;
            lap_min_r   <= MIN_ZERO;
            lap_sec_r   <= 6'd0;
            lap_valid_r <= 1'b0;
            expired_r   <= 1'b0;
            ovf_r       <= 1'b0;
            dir_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            min_r       <= min_n;
            sec_r       <= sec_n;
            lap_min_r   <= lap_min_n;
            lap_sec_r   <= lap_sec_n;
            lap_valid_r <= lap_valid_n;
            expired_r   <= expired_n;
            ovf_r       <= ovf_n;
            dir_r       <= dir_n;
        end
    end

    assign state     = state_r;
    assign min       = min_r;
    assign sec       = sec_r;
    assign lap_min   = lap_min_r;
    assign lap_sec   = lap_sec_r;
    assign lap_valid = lap_valid_r;
    assign expired   = expired_r;
    assign ovf       = ovf_r;
    assign tick      = tick_s;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench: instance A (CLK_DIV=4, MAX_MIN=59) and instance B
// (CLK_DIV=1, MAX_MIN=2) driven from one linear stimulus sequence.
module tb_stopwatch_timer;

    localparam logic [2:0] NOP = 3'd0, START = 3'd1, STOP = 3'd2,
                           RST = 3'd3, LAP = 3'd4, LOAD = 3'd5;

    logic       clk, rst;
    logic [2:0] cmd_a, cmd_b;
    logic       dir_a, dir_b;
    logic [5:0] pmin_a, psec_a, pmin_b, psec_b;
    logic [2:0] state_a, state_b;
    logic [5:0] min_a, sec_a, lmin_a, lsec_a, min_b, sec_b, lmin_b, lsec_b;
    logic       lv_a, exp_a, ovf_a, tick_a, lv_b, exp_b, ovf_b, tick_b;

    int checks = 0;
    int errors = 0;

    stopwatch_timer #(.CLK_DIV(4), .MIN_W(6), .MAX_MIN(59)) dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_a), .dir(dir_a),
        .preset_min(pmin_a), .preset_sec(psec_a),
        .state(state_a), .min(min_a), .sec(sec_a),
        .lap_min(lmin_a), .lap_sec(lsec_a), .lap_valid(lv_a),
        .expired(exp_a), .ovf(ovf_a), .tick(tick_a)
    );

    stopwatch_timer #(.CLK_DIV(1), .MIN_W(6), .MAX_MIN(2)) dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_b), .dir(dir_b),
        .preset_min(pmin_b), .preset_sec(psec_b),
        .state(state_b), .min(min_b), .sec(sec_b),
        .lap_min(lmin_b), .lap_sec(lsec_b), .lap_valid(lv_b),
        .expired(exp_b), .ovf(ovf_b), .tick(tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        cmd_a = NOP; dir_a = 1'b0; pmin_a = 6'd0; psec_a = 6'd0;
        cmd_b = NOP; dir_b = 1'b0; pmin_b = 6'd0; psec_b = 6'd0;
        cyc(2);
        chk("rst_state_a", 32'(state_a), 32'd0);
        chk("rst_min_a",   32'(min_a),   32'd0);
        chk("rst_sec_a",   32'(sec_a),   32'd0);
        chk("rst_flags_b", 32'({lv_b, exp_b, ovf_b, tick_b}), 32'd0);
        rst = 1'b1;
        cyc(1);

        // A: count up with prescaler of 4
        cmd_a = START; dir_a = 1'b0; cyc(1); cmd_a = NOP;
        chk("a_run", 32'(state_a), 32'd1);
        cyc(244);
        chk("a_61s_min", 32'(min_a), 32'd1);
        chk("a_61s_sec", 32'(sec_a), 32'd1);
        chk("a_tick_lo", 32'(tick_a), 32'd0);
        cyc(1);
        cmd_a = STOP; cyc(1); cmd_a = NOP;
        chk("a_pause", 32'(state_a), 32'd2);
        cyc(20);
        chk("a_frozen_sec",   32'(sec_a),   32'd1);
        chk("a_frozen_min",   32'(min_a),   32'd1);
        chk("a_frozen_state", 32'(state_a), 32'd2);
        chk("a_frozen_tick",  32'(tick_a),  32'd0);
        cmd_a = START; cyc(1); cmd_a = NOP;
        chk("a_resume", 32'(state_a), 32'd1);
        chk("a_resume_tick0", 32'(tick_a), 32'd0);
        cyc(1);
        chk("a_phase_tick", 32'(tick_a), 32'd1);
        chk("a_phase_sec",  32'(sec_a),  32'd1);
        cyc(1);
        chk("a_sec2", 32'(sec_a), 32'd2);
        cyc(3);
        chk("a_tick_period", 32'(tick_a), 32'd1);
        cmd_a = STOP; cyc(1); cmd_a = NOP;
        chk("a_tickstop_sec",   32'(sec_a),   32'd3);
        chk("a_tickstop_state", 32'(state_a), 32'd2);
        cmd_a = LAP; cyc(1); cmd_a = NOP;
        chk("a_plap_sec",   32'(lsec_a), 32'd3);
        chk("a_plap_min",   32'(lmin_a), 32'd1);
        chk("a_plap_valid", 32'(lv_a),   32'd1);
        chk("a_plap_state", 32'(state_a), 32'd2);
        cyc(1);
        chk("a_plap_valid_drop", 32'(lv_a), 32'd0);
        cmd_a = RST; cyc(1); cmd_a = NOP;
        chk("a_clear", 32'(state_a), 32'd3);
        cyc(1);
        chk("a_idle",    32'(state_a), 32'd0);
        chk("a_idle_ms", 32'({min_a, sec_a}), 32'd0);
        chk("a_lap_kept", 32'(lsec_a), 32'd3);

        // B: load clamp, then countdown from 1:05
        pmin_b = 6'd5; psec_b = 6'd63; cmd_b = LOAD; cyc(1);
        chk("b_clamp_sec", 32'(sec_b), 32'd59);
        chk("b_clamp_min", 32'(min_b), 32'd2);
        pmin_b = 6'd1; psec_b = 6'd5; cyc(1); cmd_b = NOP;
        chk("b_load_sec", 32'(sec_b), 32'd5);
        chk("b_load_min", 32'(min_b), 32'd1);
        cyc(3);
        chk("b_idle_hold", 32'({min_b, sec_b}), 32'({6'd1, 6'd5}));
        dir_b = 1'b1; cmd_b = START; cyc(1);
        pmin_b = 6'd2; psec_b = 6'd0; cmd_b = LOAD; cyc(1); cmd_b = NOP; dir_b = 1'b0;
        chk("b_load_ignored", 32'({min_b, sec_b}), 32'({6'd1, 6'd4}));
        cyc(5);
        chk("b_borrow", 32'({min_b, sec_b}), 32'({6'd0, 6'd59}));
        cyc(58);
        chk("b_one_left", 32'({min_b, sec_b}), 32'({6'd0, 6'd1}));
        chk("b_still_run", 32'(state_b), 32'd1);
        cmd_b = STOP; cyc(1); cmd_b = NOP;
        chk("b_done", 32'(state_b), 32'd4);
        chk("b_expired", 32'(exp_b), 32'd1);
        chk("b_zero", 32'({min_b, sec_b}), 32'd0);
        cmd_b = START; cyc(1); cmd_b = STOP; cyc(1); cmd_b = NOP;
        chk("b_done_hold", 32'(state_b), 32'd4);
        chk("b_done_exp", 32'(exp_b), 32'd1);
        cmd_b = RST; cyc(1); cmd_b = NOP;
        chk("b_clear", 32'(state_b), 32'd3);
        cyc(1);
        chk("b_exp_cleared", 32'(exp_b), 32'd0);
        chk("b_idle", 32'(state_b), 32'd0);

        // B: count up, lap coinciding with tick at 0:07, then overflow
        dir_b = 1'b0; cmd_b = START; cyc(1); cmd_b = NOP;
        chk("b_up_run", 32'(state_b), 32'd1);
        chk("b_tick_every", 32'(tick_b), 32'd1);
        cyc(7);
        chk("b_at7", 32'(sec_b), 32'd7);
        cmd_b = LAP; cyc(1); cmd_b = NOP;
        chk("b_lap_sec", 32'(lsec_b), 32'd7);
        chk("b_lap_min", 32'(lmin_b), 32'd0);
        chk("b_lap_valid", 32'(lv_b), 32'd1);
        chk("b_sec8", 32'(sec_b), 32'd8);
        cyc(1);
        chk("b_lap_pulse", 32'(lv_b), 32'd0);
        cyc(170);
        chk("b_2_59", 32'({min_b, sec_b}), 32'({6'd2, 6'd59}));
        chk("b_no_ovf", 32'(ovf_b), 32'd0);
        cyc(1);
        chk("b_wrap", 32'({min_b, sec_b}), 32'd0);
        chk("b_ovf", 32'(ovf_b), 32'd1);
        chk("b_ovf_run", 32'(state_b), 32'd1);
        cyc(2);
        chk("b_ovf_sticky", 32'(ovf_b), 32'd1);
        chk("b_after_wrap", 32'(sec_b), 32'd2);
        cmd_b = RST; cyc(1); cmd_b = NOP;
        chk("b_ovf_clear_state", 32'(state_b), 32'd3);
        cyc(1);
        chk("b_ovf_idle", 32'(state_b), 32'd0);
        chk("b_ovf_cleared", 32'(ovf_b), 32'd0);
        chk("b_ovf_ms", 32'({min_b, sec_b}), 32'd0);

        // B: asynchronous reset between clock edges while running
        cmd_b = START; cyc(1); cmd_b = NOP;
        cyc(3);
        chk("b_pre_rst", 32'(sec_b), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_state_b", 32'(state_b), 32'd0);
        chk("async_ms_b",    32'({min_b, sec_b}), 32'd0);
        chk("async_lap_b",   32'(lsec_b), 32'd0);
        chk("async_tick_b",  32'(tick_b), 32'd0);
        chk("async_lap_a",   32'(lsec_a), 32'd0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        dir_b = 1'b1; cmd_b = START; cyc(1); cmd_b = NOP;
        chk("b_zero_start_done", 32'(state_b), 32'd4);
        chk("b_zero_start_exp",  32'(exp_b),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
